// File: rtl/lookahead_mpram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lookahead_mpram_pkg: shared FSM encoding and sizing helper for the MPRAM   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package lookahead_mpram_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >>> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lookahead_mpram_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lookahead_mpram_bank: 1W/1R byte-enabled RAM with a registered read        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lookahead_mpram_bank #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  w_rd_valid;

    assign w_rd_valid = ({1'b0, raddr} < DEPTH_W);

    // Read-before-write: a same-edge write is merged by the owner of this bank.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (wbe[b]) begin
                    r_mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_rd_valid) begin
            rdata <= r_mem[raddr];
        end else begin
            rdata <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lookahead_mpram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lookahead_mpram: multi-read-port RAM with write lookahead and bulk clear   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lookahead_mpram
    import lookahead_mpram_pkg::*;
#(
    parameter  int DATA_WIDTH     = 16,
    parameter  int DEPTH          = 4,
    parameter  int NUM_RD         = 2,
    parameter  int CLEAR_ON_RESET = 1,
    localparam int ADDR_WIDTH     = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
    localparam int BE_WIDTH       = DATA_WIDTH / 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [ADDR_WIDTH-1:0]        wr_address,
    input  logic [DATA_WIDTH-1:0]        wr_writedata,
    input  logic [BE_WIDTH-1:0]          wr_byteenable,
    input  logic                         wr_write,
    output logic                         wr_waitrequest,
    input  logic                         clr_req,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_address,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_readdata
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_W     = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
    localparam state_t                RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic [ADDR_WIDTH-1:0] w_clr_cnt_next;
    logic                  r_waitreq;

    logic                  w_wr_in_range;
    logic                  w_user_we;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [BE_WIDTH-1:0]   w_wbe;
    logic [DATA_WIDTH-1:0] w_be_mask;
    logic [DATA_WIDTH-1:0] r_byp_data;
    logic [DATA_WIDTH-1:0] r_byp_mask;

    assign w_wr_in_range  = ({1'b0, wr_address} < DEPTH_W);
    assign w_user_we      = reset_n && wr_write && !r_waitreq && w_wr_in_range;
    assign wr_waitrequest = r_waitreq;

    // The clear sweep reuses the single write port, so lookahead sees it too.
    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        w_we           = 1'b0;
        w_waddr        = wr_address;
        w_wdata        = wr_writedata;
        w_wbe          = wr_byteenable;
        case (r_state)
            ST_IDLE: begin
                w_we = w_user_we;
                if (clr_req) begin
                    w_state_next   = ST_CLEAR;
                    w_clr_cnt_next = LAST_ADDR;
                end
            end
            ST_CLEAR: begin
                w_we    = reset_n;
                w_waddr = r_clr_cnt;
                w_wdata = '0;
                w_wbe   = '1;
                if (r_clr_cnt == '0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_clr_cnt_next = r_clr_cnt - 1'b1;
                end
            end
            default: begin
                w_state_next = RESET_STATE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= RESET_STATE;
            r_clr_cnt <= LAST_ADDR;
            r_waitreq <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
            r_waitreq <= (w_state_next == ST_CLEAR);
        end
    end

    for (genvar b = 0; b < BE_WIDTH; b++) begin : g_mask
        assign w_be_mask[b*8 +: 8] = {8{w_wbe[b]}};
    end

    always_ff @(posedge clk) begin
        r_byp_data <= w_wdata & w_be_mask;
        r_byp_mask <= w_be_mask;
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_raddr;
        logic [DATA_WIDTH-1:0] w_q;
        logic                  r_hit;
        logic                  r_zero;

        assign w_raddr = rd_address[i*ADDR_WIDTH +: ADDR_WIDTH];

        lookahead_mpram_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_bank (
            .clk   (clk),
            .we    (w_we),
            .waddr (w_waddr),
            .wdata (w_wdata),
            .wbe   (w_wbe),
            .raddr (w_raddr),
            .rdata (w_q)
        );

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_hit  <= 1'b0;
                r_zero <= 1'b1;
            end else begin
                r_hit  <= w_we && (w_waddr == w_raddr);
                r_zero <= (r_state == ST_CLEAR) || !({1'b0, w_raddr} < DEPTH_W);
            end
        end

        assign rd_readdata[i*DATA_WIDTH +: DATA_WIDTH] =
            r_zero ? '0 :
            r_hit  ? ((w_q & ~r_byp_mask) | r_byp_data) : w_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_lookahead_mpram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lookahead_mpram: directed and model-checked bench for lookahead_mpram   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_lookahead_mpram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Instance A: defaults (16-bit, 4 words, 2 ports, clear on reset)
    logic [1:0]  a_wr_address;
    logic [15:0] a_wr_writedata;
    logic [1:0]  a_wr_byteenable;
    logic        a_wr_write;
    logic        a_wr_waitrequest;
    logic        a_clr_req;
    logic [3:0]  a_rd_address;
    logic [31:0] a_rd_readdata;

    // Instance B: 5 words, 3 ports
    logic [2:0]  b_wr_address;
    logic [15:0] b_wr_writedata;
    logic [1:0]  b_wr_byteenable;
    logic        b_wr_write;
    logic        b_wr_waitrequest;
    logic        b_clr_req;
    logic [8:0]  b_rd_address;
    logic [47:0] b_rd_readdata;

    // Instance C: no clear on reset, 1 port
    logic [1:0]  c_wr_address;
    logic [15:0] c_wr_writedata;
    logic [1:0]  c_wr_byteenable;
    logic        c_wr_write;
    logic        c_wr_waitrequest;
    logic        c_clr_req;
    logic [1:0]  c_rd_address;
    logic [15:0] c_rd_readdata;

    lookahead_mpram #(.DATA_WIDTH(16), .DEPTH(4), .NUM_RD(2), .CLEAR_ON_RESET(1)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .wr_address(a_wr_address), .wr_writedata(a_wr_writedata),
        .wr_byteenable(a_wr_byteenable), .wr_write(a_wr_write),
        .wr_waitrequest(a_wr_waitrequest), .clr_req(a_clr_req),
        .rd_address(a_rd_address), .rd_readdata(a_rd_readdata)
    );

    lookahead_mpram #(.DATA_WIDTH(16), .DEPTH(5), .NUM_RD(3), .CLEAR_ON_RESET(1)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .wr_address(b_wr_address), .wr_writedata(b_wr_writedata),
        .wr_byteenable(b_wr_byteenable), .wr_write(b_wr_write),
        .wr_waitrequest(b_wr_waitrequest), .clr_req(b_clr_req),
        .rd_address(b_rd_address), .rd_readdata(b_rd_readdata)
    );

    lookahead_mpram #(.DATA_WIDTH(16), .DEPTH(4), .NUM_RD(1), .CLEAR_ON_RESET(0)) dut_c (
        .clk(clk), .reset_n(reset_n),
        .wr_address(c_wr_address), .wr_writedata(c_wr_writedata),
        .wr_byteenable(c_wr_byteenable), .wr_write(c_wr_write),
        .wr_waitrequest(c_wr_waitrequest), .clr_req(c_clr_req),
        .rd_address(c_rd_address), .rd_readdata(c_rd_readdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                          input logic [1:0] be);
        return {be[1] ? new_w[15:8] : old_w[15:8], be[0] ? new_w[7:0] : old_w[7:0]};
    endfunction

    logic [15:0] m [5];
    int          left;
    int          na, nb, nc;
    int          ra [3];
    int          wa;
    logic [15:0] wd;
    logic [1:0]  be;
    logic        we, cr, acc;
    logic [15:0] exp_rd [3];

    initial begin
        reset_n = 1'b0;
        a_wr_address = '0; a_wr_writedata = '0; a_wr_byteenable = '0; a_wr_write = 1'b0;
        a_clr_req = 1'b0; a_rd_address = '0;
        b_wr_address = '0; b_wr_writedata = '0; b_wr_byteenable = '0; b_wr_write = 1'b0;
        b_clr_req = 1'b0; b_rd_address = '0;
        c_wr_address = '0; c_wr_writedata = '0; c_wr_byteenable = '0; c_wr_write = 1'b0;
        c_clr_req = 1'b0; c_rd_address = '0;
        tick(); tick(); tick();

        chk("rst_a_wait", 48'(a_wr_waitrequest), 48'd1);
        chk("rst_a_rd",   48'(a_rd_readdata), 48'd0);
        chk("rst_b_wait", 48'(b_wr_waitrequest), 48'd1);
        chk("rst_b_rd",   b_rd_readdata, 48'd0);
        chk("rst_c_wait", 48'(c_wr_waitrequest), 48'd1);
        chk("rst_c_rd",   48'(c_rd_readdata), 48'd0);

        // Release and count waitrequest-high cycles on every instance
        reset_n = 1'b1;
        na = int'(a_wr_waitrequest);
        nb = int'(b_wr_waitrequest);
        nc = int'(c_wr_waitrequest);
        for (int k = 0; k < 8; k++) begin
            tick();
            na += int'(a_wr_waitrequest);
            nb += int'(b_wr_waitrequest);
            nc += int'(c_wr_waitrequest);
        end
        chk("clr_cycles_a", 48'(na), 48'd4);
        chk("clr_cycles_b", 48'(nb), 48'd5);
        chk("noclr_cycles_c", 48'(nc), 48'd1);

        for (int a = 0; a < 4; a++) begin
            a_rd_address = {2'(3 - a), 2'(a)};
            tick();
            chk($sformatf("post_clr_a_p0_%0d", a), 48'(a_rd_readdata[15:0]), 48'd0);
            chk($sformatf("post_clr_a_p1_%0d", 3 - a), 48'(a_rd_readdata[31:16]), 48'd0);
        end

        // Lookahead: write and read the same address on the same edge
        a_wr_address = 2'd2; a_wr_writedata = 16'hBEEF; a_wr_byteenable = 2'b11; a_wr_write = 1'b1;
        a_rd_address = {2'd2, 2'd2};
        tick();
        a_wr_write = 1'b0;
        chk("lookahead_p0", 48'(a_rd_readdata[15:0]), 48'hBEEF);
        chk("lookahead_p1", 48'(a_rd_readdata[31:16]), 48'hBEEF);
        tick();
        chk("readback_beef", 48'(a_rd_readdata[15:0]), 48'hBEEF);

        // Byte-enable lookahead merge
        a_wr_address = 2'd1; a_wr_writedata = 16'h1234; a_wr_byteenable = 2'b11; a_wr_write = 1'b1;
        tick();
        a_wr_writedata = 16'hAB00; a_wr_byteenable = 2'b10;
        a_rd_address = {2'd1, 2'd0};
        tick();
        a_wr_write = 1'b0;
        chk("be_merge_p1", 48'(a_rd_readdata[31:16]), 48'hAB34);
        chk("be_other_p0", 48'(a_rd_readdata[15:0]), 48'h0000);
        a_rd_address = {2'd1, 2'd1};
        tick();
        chk("be_readback_p0", 48'(a_rd_readdata[15:0]), 48'hAB34);

        // clr_req coincident with a write; writes and clr_req during the sweep are ignored
        a_wr_address = 2'd3; a_wr_writedata = 16'h5555; a_wr_byteenable = 2'b11; a_wr_write = 1'b1;
        a_clr_req = 1'b1;
        a_rd_address = {2'd1, 2'd3};
        tick();
        chk("clr_wait_0", 48'(a_wr_waitrequest), 48'd1);
        chk("clr_look_p0", 48'(a_rd_readdata[15:0]), 48'h5555);
        chk("clr_pre_p1", 48'(a_rd_readdata[31:16]), 48'hAB34);
        a_wr_address = 2'd0; a_wr_writedata = 16'h7777;
        tick();
        chk("clr_wait_1", 48'(a_wr_waitrequest), 48'd1);
        chk("clr_rd0_p0", 48'(a_rd_readdata[15:0]), 48'h0000);
        chk("clr_rd0_p1", 48'(a_rd_readdata[31:16]), 48'h0000);
        tick();
        chk("clr_wait_2", 48'(a_wr_waitrequest), 48'd1);
        tick();
        chk("clr_wait_3", 48'(a_wr_waitrequest), 48'd1);
        tick();
        chk("clr_wait_4", 48'(a_wr_waitrequest), 48'd0);
        a_wr_write = 1'b0;
        a_clr_req  = 1'b0;
        for (int a = 0; a < 4; a++) begin
            a_rd_address = {2'(a), 2'(a)};
            tick();
            chk($sformatf("after_clr_p0_%0d", a), 48'(a_rd_readdata[15:0]), 48'd0);
            chk($sformatf("after_clr_p1_%0d", a), 48'(a_rd_readdata[31:16]), 48'd0);
        end
        chk("idle_wait_a", 48'(a_wr_waitrequest), 48'd0);

        // Instance without clear on reset accepts writes right away
        c_wr_address = 2'd2; c_wr_writedata = 16'h1111; c_wr_byteenable = 2'b11; c_wr_write = 1'b1;
        c_rd_address = 2'd2;
        tick();
        c_wr_write = 1'b0;
        chk("c_lookahead", 48'(c_rd_readdata), 48'h1111);

        // Out-of-range handling with DEPTH=5
        for (int a = 0; a < 5; a++) begin
            b_wr_address = 3'(a); b_wr_writedata = 16'h1000 + 16'(a);
            b_wr_byteenable = 2'b11; b_wr_write = 1'b1;
            tick();
        end
        b_wr_address = 3'd6; b_wr_writedata = 16'hFFFF;
        b_rd_address = {3'd6, 3'd4, 3'd6};
        tick();
        b_wr_write = 1'b0;
        chk("oor_rd6_p0", 48'(b_rd_readdata[15:0]), 48'h0000);
        chk("oor_rd4_p1", 48'(b_rd_readdata[31:16]), 48'h1004);
        chk("oor_rd6_p2", 48'(b_rd_readdata[47:32]), 48'h0000);
        for (int a = 0; a < 5; a++) begin
            b_rd_address = {3'(a), 3'd7, 3'(a)};
            tick();
            chk($sformatf("oor_keep_p0_%0d", a), 48'(b_rd_readdata[15:0]), 48'h1000 + 48'(a));
            chk($sformatf("oor_rd7_p1_%0d", a), 48'(b_rd_readdata[31:16]), 48'h0000);
            chk($sformatf("oor_keep_p2_%0d", a), 48'(b_rd_readdata[47:32]), 48'h1000 + 48'(a));
        end

        // Random traffic against a reference model
        for (int a = 0; a < 5; a++) m[a] = 16'h1000 + 16'(a);
        left = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            for (int p = 0; p < 3; p++) ra[p] = int'($urandom_range(0, 7));
            wa = int'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) ra[1] = wa;
            wd = 16'($urandom);
            be = 2'($urandom_range(0, 3));
            we = 1'($urandom_range(0, 1));
            cr = ($urandom_range(0, 31) == 0);

            b_wr_address = 3'(wa); b_wr_writedata = wd; b_wr_byteenable = be;
            b_wr_write = we; b_clr_req = cr;
            b_rd_address = {3'(ra[2]), 3'(ra[1]), 3'(ra[0])};

            acc = we && (left == 0) && (wa < 5);
            for (int p = 0; p < 3; p++) begin
                if (left > 0 || ra[p] >= 5) begin
                    exp_rd[p] = 16'h0000;
                end else begin
                    exp_rd[p] = m[ra[p]];
                    if (acc && wa == ra[p]) exp_rd[p] = merge(exp_rd[p], wd, be);
                end
            end
            if (left > 0) begin
                m[left - 1] = 16'h0000;
                left--;
            end else begin
                if (acc) m[wa] = merge(m[wa], wd, be);
                if (cr) left = 5;
            end

            tick();
            chk($sformatf("rnd_wait_%0d", cyc), 48'(b_wr_waitrequest), 48'(left > 0));
            for (int p = 0; p < 3; p++) begin
                chk($sformatf("rnd_p%0d_%0d", p, cyc), 48'(b_rd_readdata[p*16 +: 16]), 48'(exp_rd[p]));
            end
        end
        b_wr_write = 1'b0;
        b_clr_req  = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
